intmul_s: RTL and testbench

Sequential shift-add integer multiplier that produces the 2W-bit product A = X·Y consumed by the shift-based K²-RED reducer (k2red_s). It sits directly upstream of the reducer in the modular-multiplication datapath. It accepts operand pairs over a valid/ready handshake, computes one multiplier bit per clock, and presents the full-width product over a second valid/ready handshake.

---
 rtl/intmul_s.sv | 88 ++++++++
 tb/tb_intmul_s.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/intmul_s.sv
// intmul_s: sequential shift-add multiplier, one multiplier bit per clock, A = X*Y over valid/ready.
// Optional INTMUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module intmul_s #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] A
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
`ifdef INTMUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] xs_q, xs_d, acc_q, acc_d, a_q, a_d;
    logic [W-1:0]   ys_q, ys_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_step;

    // Early exit looks at the multiplier after this step's shift.
    assign last_step = (cnt_q == CW'(W - 1)) || (EARLY && (ys_q >> 1) == '0);

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        case (state_q)
            IDLE: if (in_valid) begin
                xs_d    = {{W{1'b0}}, X};
                ys_d    = Y;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d = ys_q[0] ? acc_q + xs_q : acc_q;
                xs_d  = xs_q << 1;
                ys_d  = ys_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = DONE;
                    a_d     = acc_d;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                a_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign A         = a_q;
endmodule

// File: tb/tb_intmul_s.sv
// tb_intmul_s: directed and random checks of intmul_s against a queued X*Y reference.
module tb_intmul_s;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   X = '0;
    logic [W-1:0]   Y = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] A;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];
    int lat_q[$];

    intmul_s #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
        .out_valid(out_valid), .out_ready(out_ready), .A(A)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] y);
`ifdef INTMUL_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < W; i++) if (y[i]) m = i + 1;
        return (m == 0) ? 1 : m;
`else
        return W;
`endif
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; X = x; Y = y;
        sb.push_back({{W{1'b0}}, x} * {{W{1'b0}}, y});
        lat_q.push_back(lat_of(y));
        @(posedge clk); #1;
        in_valid = 1'b0; X = {$urandom, $urandom}; Y = {$urandom, $urandom};
    endtask

    task automatic recv(input string tag, input int stall);
        int n = 0;
        logic [2*W-1:0] exp;
        int lat;
        out_ready = 1'b0;
        while (!out_valid && n < 300) begin
            chk({tag, "_busy_in_ready"}, 128'(in_ready), 128'(0));
            @(posedge clk); #1; n++;
        end
        exp = sb.size() ? sb.pop_front() : 'x;
        lat = lat_q.size() ? lat_q.pop_front() : -1;
        chk({tag, "_latency"}, 128'(n), 128'(lat));
        chk({tag, "_A"}, A, exp);
        chk({tag, "_in_ready_done"}, 128'(in_ready), 128'(0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_stall_A"}, A, exp);
            chk({tag, "_stall_in_ready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_after_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_after_in_ready"}, 128'(in_ready), 128'(1));
        chk({tag, "_after_A"}, A, 128'(0));
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_A", A, 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        send(64'd3, 64'd5);
        recv("basic", 0);

        send({W{1'b1}}, {W{1'b1}});
        chk("max_ref", sb[0], 128'hFFFFFFFFFFFFFFFE0000000000000001);
        recv("max", 0);

        send(64'd12345, 64'd0);
        recv("zero", 0);

        send(64'd9223336852482686977, 64'd2);
        chk("bp_ref", sb[0], 128'd18446673704965373954);
        recv("backpressure", 5);
        send(64'd11, 64'd13);
        recv("after_bp", 1);

        send({W{1'b1}}, {W{1'b1}});
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_A", A, 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
        void'(sb.pop_front());
        void'(lat_q.pop_front());
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) chk("rst_stale_valid", 128'(out_valid), 128'(0));
        end
        chk("rst_idle_A", A, 128'(0));
        out_ready = 1'b0;
        send(64'd7, 64'd6);
        chk("rst_new_ref", sb[0], 128'd42);
        recv("after_rst", 0);

        for (int k = 0; k < 1000; k++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            if (k % 4 == 1) ry = ry >> $urandom_range(1, W - 1);
            if (k % 50 == 7) ry = '0;
            send(rx, ry);
            recv("rand", $urandom_range(0, 3));
        end
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
